// File: rtl/spi_xfer_sequencer.sv
// spi_xfer_sequencer: runs two-byte SPI register transfers through an SPI core register interface
module spi_xfer_sequencer #(
  parameter int unsigned POLL_LIMIT = 1023,
  parameter logic [15:0] SS_MASK    = 16'h0001
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req,
  input  logic        req_wr,
  input  logic [4:0]  req_reg,
  input  logic [7:0]  req_wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [7:0]  rdata,
  output logic        spi_select,
  output logic [2:0]  mem_addr,
  output logic [15:0] data_from_cpu,
  output logic        read_n,
  output logic        write_n,
  input  logic [15:0] data_to_cpu
);
  localparam int CW = ($clog2(POLL_LIMIT + 1) < 10) ? 10 : $clog2(POLL_LIMIT + 1);
  typedef enum logic [3:0] {
    INIT, IDLE, SSO_ON, POLL_TRDY, WR_TX, POLL_RRDY, RD_RX, POLL_TMT, SSO_OFF, DONE
  } state_t;
  state_t state_q, state_d;
  logic [1:0] ph_q, ph_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic bsel_q, bsel_d, ok_q, ok_d, wr_q, wr_d;
  logic [4:0] rreg_q, rreg_d;
  logic [7:0] wdata_q, wdata_d, rdata_q, rdata_d, tx_byte;
  logic err_q, err_d, busy_q, busy_d, done_q, done_d;
  logic sel_q, sel_d, read_n_q, read_n_d, write_n_q, write_n_d;
  logic [2:0] addr_q, addr_d;
  logic [15:0] dout_q, dout_d;
  logic is_acc, is_poll, stat_ok, act_d, rd_acc_d;
  logic unused_hi;
  assign unused_hi = ^data_to_cpu[15:8];
  // Next-state and next-output logic; ph counts strobe cycles 0,1 then idle gap 2 (3 = pre-access after reset)
  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    cnt_d   = cnt_q;
    bsel_d  = bsel_q;
    ok_d    = ok_q;
    wr_d    = wr_q;
    rreg_d  = rreg_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    is_acc  = !(state_q inside {IDLE, DONE});
    is_poll = state_q inside {POLL_TRDY, POLL_RRDY, POLL_TMT};
    stat_ok = state_q == POLL_TRDY ? data_to_cpu[6] : state_q == POLL_RRDY ? data_to_cpu[7] : data_to_cpu[5];
    if (state_q == IDLE && req) begin
      state_d = SSO_ON;
      ph_d    = 2'd0;
      wr_d    = req_wr;
      rreg_d  = req_reg;
      wdata_d = req_wdata;
      err_d   = 1'b0;
      bsel_d  = 1'b0;
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end else if (is_acc) begin
      if (ph_q == 2'd1 && is_poll) ok_d = stat_ok;
      if (ph_q == 2'd1 && state_q == RD_RX && bsel_q) rdata_d = data_to_cpu[7:0];
      if (ph_q != 2'd2) ph_d = ph_q + 2'd1;
      else begin
        ph_d = 2'd0;
        case (state_q)
          INIT:    state_d = IDLE;
          SSO_ON:  state_d = POLL_TRDY;
          WR_TX:   state_d = POLL_RRDY;
          RD_RX:   begin
            state_d = bsel_q ? POLL_TMT : POLL_TRDY;
            bsel_d  = 1'b1;
          end
          SSO_OFF: state_d = DONE;
          default: begin
            if (ok_q) state_d = state_q == POLL_TRDY ? WR_TX : state_q == POLL_RRDY ? RD_RX : SSO_OFF;
            else if (cnt_q == CW'(POLL_LIMIT - 1)) begin
              state_d = SSO_OFF;
              err_d   = 1'b1;
            end else cnt_d = cnt_q + 1'b1;
          end
        endcase
      end
    end
    if (state_d != state_q) cnt_d = '0;
    act_d     = !(state_d inside {IDLE, DONE}) && !ph_d[1];
    rd_acc_d  = state_d inside {POLL_TRDY, POLL_RRDY, POLL_TMT, RD_RX};
    sel_d     = act_d;
    read_n_d  = !(act_d && rd_acc_d);
    write_n_d = !(act_d && !rd_acc_d);
    tx_byte   = bsel_d ? (wr_d ? wdata_d : 8'h00) : {rreg_d, 1'b0, wr_d, 1'b0};
    addr_d    = !act_d ? 3'd0 : state_d == INIT ? 3'd5 : state_d inside {SSO_ON, SSO_OFF} ? 3'd3 :
                rd_acc_d && state_d != RD_RX ? 3'd2 : state_d == WR_TX ? 3'd1 : 3'd0;
    dout_d    = !act_d ? 16'h0 : state_d == INIT ? SS_MASK : state_d == SSO_ON ? 16'h0400 :
                state_d == WR_TX ? {8'h00, tx_byte} : 16'h0;
    busy_d    = !(state_d inside {INIT, IDLE});
    done_d    = state_d == DONE;
  end
  // State and registered outputs; reset parks the FSM just before the INIT access
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= INIT;
      ph_q      <= 2'd3;
      cnt_q     <= '0;
      bsel_q    <= 1'b0;
      ok_q      <= 1'b0;
      wr_q      <= 1'b0;
      rreg_q    <= '0;
      wdata_q   <= '0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      sel_q     <= 1'b0;
      read_n_q  <= 1'b1;
      write_n_q <= 1'b1;
      addr_q    <= '0;
      dout_q    <= '0;
    end else begin
      state_q   <= state_d;
      ph_q      <= ph_d;
      cnt_q     <= cnt_d;
      bsel_q    <= bsel_d;
      ok_q      <= ok_d;
      wr_q      <= wr_d;
      rreg_q    <= rreg_d;
      wdata_q   <= wdata_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      sel_q     <= sel_d;
      read_n_q  <= read_n_d;
      write_n_q <= write_n_d;
      addr_q    <= addr_d;
      dout_q    <= dout_d;
    end
  end
  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;
  assign rdata         = rdata_q;
  assign spi_select    = sel_q;
  assign mem_addr      = addr_q;
  assign data_from_cpu = dout_q;
  assign read_n        = read_n_q;
  assign write_n       = write_n_q;
endmodule

// File: tb/tb_spi_xfer_sequencer.sv
// tb_spi_xfer_sequencer: directed checks of the SPI transfer sequencer against a small SPI core model
module tb_spi_xfer_sequencer;
  logic clk = 0, reset_n = 0, req = 0, req_wr = 0;
  logic [4:0] req_reg = 0;
  logic [7:0] req_wdata = 0;
  logic busy, done, err, spi_select, read_n, write_n;
  logic [7:0] rdata;
  logic [2:0] mem_addr;
  logic [15:0] data_from_cpu, data_to_cpu;
  int n_checks = 0, n_fail = 0;
  logic rrdy_en = 1;
  logic [7:0] miso1 = 0;
  int tx_cnt = 0, stat_reads = 0, done_cnt = 0, proto_err = 0, lo_len = 0;
  logic [2:0] acc_addr = 0;
  logic [15:0] acc_data = 0;
  logic [18:0] wlog[$];

  spi_xfer_sequencer dut (
    .clk(clk), .reset_n(reset_n), .req(req), .req_wr(req_wr), .req_reg(req_reg),
    .req_wdata(req_wdata), .busy(busy), .done(done), .err(err), .rdata(rdata),
    .spi_select(spi_select), .mem_addr(mem_addr), .data_from_cpu(data_from_cpu),
    .read_n(read_n), .write_n(write_n), .data_to_cpu(data_to_cpu)
  );

  always #5 clk = ~clk;

  assign data_to_cpu = mem_addr == 3'd2 ? {8'h00, rrdy_en, 7'h60} :
                       mem_addr == 3'd0 ? {8'h00, (tx_cnt == 2) ? miso1 : 8'h55} : 16'h0000;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [18:0] wl(input int i);
    return (i < wlog.size()) ? wlog[i] : 19'h7ffff;
  endfunction

  always @(negedge clk) begin
    if (!reset_n) lo_len = 0;
    else begin
      if (done) done_cnt++;
      if (spi_select) begin
        if (read_n == write_n) proto_err++;
        if (lo_len == 0) begin
          acc_addr = mem_addr;
          acc_data = data_from_cpu;
          if (!write_n) begin
            wlog.push_back({mem_addr, data_from_cpu});
            if (mem_addr == 3'd1) tx_cnt++;
            if (mem_addr == 3'd3 && data_from_cpu == 16'h0400) tx_cnt = 0;
          end
          if (!read_n && mem_addr == 3'd2) stat_reads++;
        end else if (mem_addr != acc_addr || data_from_cpu != acc_data) proto_err++;
        lo_len++;
      end else begin
        if (!read_n || !write_n) proto_err++;
        if (lo_len != 0 && lo_len != 2) proto_err++;
        lo_len = 0;
      end
    end
  end

  task automatic xfer(input logic wr, input logic [4:0] r, input logic [7:0] wd,
                      output logic e, output logic [7:0] rd, output int ok);
    int t;
    wlog.delete();
    stat_reads = 0;
    ok = 0;
    e = 1'bx;
    rd = 8'hxx;
    @(negedge clk);
    req = 1; req_wr = wr; req_reg = r; req_wdata = wd;
    t = 0;
    while (!busy && t < 50) begin @(negedge clk); t++; end
    req = 0; req_reg = ~r; req_wdata = ~wd; req_wr = ~wr;
    t = 0;
    while (!done && t < 5000) begin @(negedge clk); t++; end
    if (done) begin ok = 1; e = err; rd = rdata; end
  endtask

  initial begin
    logic e;
    logic [7:0] rd;
    int ok, t, dn, dn0;
    repeat (3) @(negedge clk);
    check("rst_sel", spi_select, 0);
    check("rst_rdn", read_n, 1);
    check("rst_wrn", write_n, 1);
    check("rst_addr", mem_addr, 0);
    check("rst_dout", data_from_cpu, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_rdata", rdata, 0);
    reset_n = 1;
    repeat (12) @(negedge clk);
    check("init_nwr", wlog.size(), 1);
    check("init_wr", wl(0), {3'd5, 16'h0001});
    check("init_busy", busy, 0);

    miso1 = 8'h66;
    xfer(1, 5'd17, 8'hA5, e, rd, ok);
    check("wr_done", ok, 1);
    check("wr_err", e, 0);
    check("wr_nwr", wlog.size(), 4);
    check("wr_sso_on", wl(0), {3'd3, 16'h0400});
    check("wr_tx0", wl(1), {3'd1, 16'h008A});
    check("wr_tx1", wl(2), {3'd1, 16'h00A5});
    check("wr_sso_off", wl(3), {3'd3, 16'h0000});
    check("wr_stat", stat_reads, 5);
    @(negedge clk);
    check("wr_idle_busy", busy, 0);

    miso1 = 8'h3C;
    xfer(0, 5'd19, 8'hFF, e, rd, ok);
    check("rd_done", ok, 1);
    check("rd_err", e, 0);
    check("rd_tx0", wl(1), {3'd1, 16'h0098});
    check("rd_tx1", wl(2), {3'd1, 16'h0000});
    check("rd_sso_off", wl(3), {3'd3, 16'h0000});
    check("rd_rdata", rd, 8'h3C);

    rrdy_en = 0;
    miso1 = 8'hEE;
    xfer(0, 5'd5, 8'h00, e, rd, ok);
    check("to_done", ok, 1);
    check("to_err", e, 1);
    check("to_rdata", rd, 8'h3C);
    check("to_stat", stat_reads, 1024);
    check("to_nwr", wlog.size(), 3);
    check("to_tx0", wl(1), {3'd1, 16'h0028});
    check("to_sso_off", wl(2), {3'd3, 16'h0000});
    rrdy_en = 1;

    wlog.delete();
    dn = 0;
    t = 0;
    @(negedge clk);
    req = 1; req_wr = 1; req_reg = 5'd2; req_wdata = 8'h11;
    while (!busy && t < 50) begin @(negedge clk); t++; end
    check("err_clr", err, 0);
    while (dn < 2 && t < 5000) begin @(negedge clk); t++; if (done) dn++; end
    req = 0;
    check("b2b_done", dn, 2);
    check("b2b_tx0", wl(5), {3'd1, 16'h0012});
    check("b2b_sso_on2", wl(4), {3'd3, 16'h0400});
    repeat (10) @(negedge clk);
    check("b2b_nwr", wlog.size(), 8);
    check("b2b_idle_busy", busy, 0);

    rrdy_en = 0;
    dn0 = done_cnt;
    stat_reads = 0;
    @(negedge clk);
    req = 1; req_wr = 0; req_reg = 5'd7;
    t = 0;
    while (!busy && t < 50) begin @(negedge clk); t++; end
    req = 0;
    while (stat_reads < 5 && t < 500) begin @(negedge clk); t++; end
    check("rst_mid_reached", stat_reads >= 5, 1);
    #2 reset_n = 0;
    #1;
    check("rst_mid_sel", spi_select, 0);
    check("rst_mid_rdn", read_n, 1);
    check("rst_mid_wrn", write_n, 1);
    check("rst_mid_busy", busy, 0);
    wlog.delete();
    rrdy_en = 1;
    repeat (2) @(negedge clk);
    reset_n = 1;
    repeat (12) @(negedge clk);
    check("rst_mid_nwr", wlog.size(), 1);
    check("rst_mid_init", wl(0), {3'd5, 16'h0001});
    check("rst_mid_nodone", done_cnt, dn0);
    check("rst_mid_idle", busy, 0);
    check("proto", proto_err, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/spi_xfer_sequencer.md
SPI_XFER_SEQUENCER -- requirements
Module: spi_xfer_sequencer

Interface
REQ-001 Parameter POLL_LIMIT, default 1023, meaning: maximum number of status reads per poll phase before the transfer is aborted.
REQ-002 Parameter SS_MASK, default 16'h0001, meaning: value written to the SPI slave-enable register during initialisation.
REQ-003 clk  input  1  system clock.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 req  input  1  client request; sampled only in IDLE.
REQ-006 req_wr  input  1  1 = register write, 0 = register read.
REQ-007 req_reg  input  5  target device register number.
REQ-008 req_wdata  input  8  write data; ignored for reads.
REQ-009 busy  output  1  high from the cycle after req is accepted until done.
REQ-010 done  output  1  single-cycle pulse at transfer end.
REQ-011 err  output  1  valid with done; 1 = poll timeout.
REQ-012 rdata  output  8  second received byte; valid with done and held until the next done.
REQ-013 spi_select  output  1  SPI core chip select.
REQ-014 mem_addr  output  3  SPI core register address.
REQ-015 data_from_cpu  output  16  SPI core write data.
REQ-016 read_n  output  1  active-low SPI core read.
REQ-017 write_n  output  1  active-low SPI core write.
REQ-018 data_to_cpu  input  16  SPI core read data.

Function
REQ-019 Every SPI core access SHALL be a two-cycle bus access: spi_select=1, mem_addr/data_from_cpu stable, and exactly one strobe low for exactly 2 consecutive cycles.
REQ-020 Every access SHALL be followed by at least 1 idle cycle with spi_select=0 and read_n=write_n=1.
REQ-021 Read data SHALL be sampled on the clock edge that ends cycle 2 of a read access.
REQ-022 The state sequence after reset SHALL be INIT (write SS_MASK to addr 5) -> IDLE.
REQ-023 On req=1 in IDLE, the block SHALL latch req_wr/req_reg/req_wdata and run the sequence SSO_ON -> {POLL_TRDY -> WR_TX -> POLL_RRDY -> RD_RX} x2 bytes -> POLL_TMT -> SSO_OFF -> DONE -> IDLE.
REQ-024 SSO_ON SHALL write 16'h0400 to addr 3; SSO_OFF SHALL write 16'h0000 to addr 3.
REQ-025 The byte-0 command SHALL be {8'h00, req_reg, 1'b0, req_wr, 1'b0}.
REQ-026 Byte 1 SHALL be req_wdata for writes and 8'h00 for reads.
REQ-027 POLL_TRDY, POLL_RRDY and POLL_TMT SHALL repeatedly read addr 2 until status bit 6, bit 7 or bit 5 respectively is 1.
REQ-028 WR_TX SHALL write the byte, zero-extended to 16 bits, to addr 1.
REQ-029 RD_RX SHALL read addr 0; the byte-0 result SHALL be discarded and data_to_cpu[7:0] of byte 1 SHALL be captured into rdata.
REQ-030 The poll counter (10 bits min, width derived from POLL_LIMIT) SHALL clear on entry to each poll state.
REQ-031 When POLL_LIMIT reads have been made without success, the block SHALL go to SSO_OFF with err latched to 1; rdata SHALL be left unchanged on error.
REQ-032 done SHALL pulse for 1 cycle in DONE; busy SHALL be 0 in IDLE and INIT.
REQ-033 req asserted while busy or in INIT SHALL be ignored (no queueing), and req must be re-asserted.
REQ-034 A req held high through DONE SHALL start a new transfer on the first IDLE cycle.
REQ-035 err SHALL clear at the start of each accepted request.

Reset
REQ-036 On reset_n=0, the block SHALL immediately enter INIT.
REQ-037 During reset, outputs SHALL be: spi_select=0, read_n=1, write_n=1, mem_addr=0, data_from_cpu=0, busy=0, done=0, err=0, rdata=0.
REQ-038 Reset asserted mid-transfer SHALL abort the transfer with no done pulse; the SPI core is reset by the same reset_n.
REQ-039 INIT SHALL begin on the first clock after reset_n deasserts.

Verification
REQ-040 Reset release -> exactly one write of 16'h0001 to addr 5, then idle with busy=0.
REQ-041 req write reg 17 data 8'hA5 with an SPI core model -> addr 3 writes 0x0400; TX writes 16'h008A, 16'h00A5; addr 3 write 0x0000; done=1, err=0.
REQ-042 req read reg 19 with MISO byte 1 = 8'h3C -> TX bytes 16'h0098, 16'h0000; rdata=8'h3C on done.
REQ-043 Status model never sets RRDY -> 1023 status reads, SSO_OFF write, done with err=1, rdata unchanged.
REQ-044 Back-to-back: req held high across two transfers -> two complete sequences, each access 2 strobe cycles plus at least 1 idle cycle.
REQ-045 reset_n pulsed low during POLL_RRDY -> strobes go inactive immediately, no done pulse, INIT write repeats after release.
